// File: rtl/m_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: func3 codes, FSM
// state encodings and the M-extension instruction identifier.
package m_unit_pkg;

   localparam logic [2:0] M_FUNC3_MUL    = 3'b000;
   localparam logic [2:0] M_FUNC3_MULH   = 3'b001;
   localparam logic [2:0] M_FUNC3_MULHSU = 3'b010;
   localparam logic [2:0] M_FUNC3_MULHU  = 3'b011;
   localparam logic [2:0] M_FUNC3_DIV    = 3'b100;
   localparam logic [2:0] M_FUNC3_DIVU   = 3'b101;
   localparam logic [2:0] M_FUNC3_REM    = 3'b110;
   localparam logic [2:0] M_FUNC3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      M_ST_IDLE = 2'd0,
      M_ST_MUL  = 2'd1,
      M_ST_DIV  = 2'd2,
      M_ST_DONE = 2'd3
   } m_state_e;

   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
   localparam logic [6:0] FUNC7_MEXT   = 7'b0000001;

   function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] func7);
      return (opcode == OPCODE_RTYPE) && (func7 == FUNC7_MEXT);
   endfunction

endpackage

// File: rtl/m_unit_if.sv
// Execute-stage <-> M unit request/result bundle.
interface m_unit_if #(parameter int XLEN = 32);
   import m_unit_pkg::*;

   // Handshake: m_start is a request valid; it is accepted only on a cycle
   // where m_unit_busy=0 and m_flush=0, so the requester holds it (with
   // operands) until busy drops. m_unit_ready is a one-cycle result strobe with
   // no back-pressure; result/wr/dest are meaningful only while it is high.
   logic            m_start;
   logic [2:0]      m_func3;
   logic [XLEN-1:0] m_op1;
   logic [XLEN-1:0] m_op2;
   logic [4:0]      m_rd;
   logic            m_flush;

   logic            m_unit_busy;
   logic            m_unit_ready;
   logic [XLEN-1:0] m_unit_result;
   logic            m_unit_wr;
   logic [4:0]      m_unit_dest;
   m_state_e        m_state;

   modport master (
      output m_start, m_func3, m_op1, m_op2, m_rd, m_flush,
      input  m_unit_busy, m_unit_ready, m_unit_result, m_unit_wr, m_unit_dest, m_state
   );

   modport slave (
      input  m_start, m_func3, m_op1, m_op2, m_rd, m_flush,
      output m_unit_busy, m_unit_ready, m_unit_result, m_unit_wr, m_unit_dest, m_state
   );

endinterface

// File: rtl/m_div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes, one quotient bit
// per step. quotient/remainder present the values after the current step.
module m_div_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvs_q;
   logic [5:0]      cnt_q;

   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] rem_nxt;
   logic [XLEN-1:0] quo_nxt;

   // Shifted partial remainder is always below 2*divisor, so a negative trial
   // leaves it fitting in XLEN bits.
   assign shifted = {rem_q, quo_q[XLEN-1]};
   assign trial   = shifted - {1'b0, dvs_q};
   assign rem_nxt = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
   assign quo_nxt = {quo_q[XLEN-2:0], ~trial[XLEN]};

   assign quotient  = quo_nxt;
   assign remainder = rem_nxt;
   assign done      = step && (cnt_q == 6'(XLEN - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= '0;
      end else if (step) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
         cnt_q <= cnt_q + 6'd1;
      end
   end

endmodule

// File: rtl/m_unit.sv
// RV32M multiply/divide unit: pipelined multiplier, iterative divider and
// single-cycle special cases, returning a one-cycle ready strobe.
module m_unit
   import m_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic     clk,
   input  logic     rst,
   m_unit_if.slave  m_if
);

   localparam int PW  = 2 * XLEN;
   localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   m_state_e        state_q, state_d;
   logic [2:0]      func3_q;
   logic [4:0]      rd_q;
   logic            neg_quo_q, neg_rem_q;
   logic [MCW-1:0]  mul_cnt_q;
   logic [PW-1:0]   mul_pipe [MUL_LATENCY];
   logic [XLEN-1:0] result_q;
   logic            wr_q;
   logic [4:0]      dest_q;

   logic            accept, div_load, div_step, div_done, done_load;
   logic            mul_s1, mul_s2, div_signed, div_by_zero, div_ovf, special;
   logic [PW-1:0]   op1_ext, op2_ext, prod;
   logic [XLEN-1:0] mag1, mag2, special_res, mul_res, div_res, quo, rem, result_d;
   logic [4:0]      dest_d;

   // Issue-side decode works straight off the request so special cases and
   // the first multiplier stage resolve in the accept cycle.
   assign accept      = (state_q == M_ST_IDLE) && m_if.m_start && !m_if.m_flush;
   assign mul_s1      = (m_if.m_func3[1:0] != 2'b11);
   assign mul_s2      = ~m_if.m_func3[1];
   assign op1_ext     = {{XLEN{m_if.m_op1[XLEN-1] & mul_s1}}, m_if.m_op1};
   assign op2_ext     = {{XLEN{m_if.m_op2[XLEN-1] & mul_s2}}, m_if.m_op2};
   assign prod        = op1_ext * op2_ext;

   assign div_signed  = ~m_if.m_func3[0];
   assign mag1        = (div_signed && m_if.m_op1[XLEN-1]) ? -m_if.m_op1 : m_if.m_op1;
   assign mag2        = (div_signed && m_if.m_op2[XLEN-1]) ? -m_if.m_op2 : m_if.m_op2;
   assign div_by_zero = (m_if.m_op2 == '0);
   assign div_ovf     = div_signed && (m_if.m_op1 == MIN_NEG) && (m_if.m_op2 == '1);
   assign special     = m_if.m_func3[2] && (div_by_zero || div_ovf);

   always_comb begin
      special_res = '0;
      if (div_by_zero) special_res = m_if.m_func3[1] ? m_if.m_op1 : '1;
      else if (div_ovf) special_res = m_if.m_func3[1] ? '0 : MIN_NEG;
   end

   m_div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (mag1),
      .divisor   (mag2),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rem)
   );

   assign mul_res = (func3_q[1:0] == 2'b00) ? mul_pipe[MUL_LATENCY-1][XLEN-1:0]
                                            : mul_pipe[MUL_LATENCY-1][PW-1:XLEN];
   assign div_res = func3_q[1] ? (neg_rem_q ? -rem : rem) : (neg_quo_q ? -quo : quo);

   always_ff @(posedge clk) begin
      if (rst) state_q <= M_ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      div_load  = 1'b0;
      div_step  = 1'b0;
      done_load = 1'b0;
      result_d  = '0;
      dest_d    = rd_q;
      unique case (state_q)
         M_ST_IDLE: begin
            dest_d   = m_if.m_rd;
            result_d = special_res;
            if (accept) begin
               if (!m_if.m_func3[2]) begin
                  state_d = M_ST_MUL;
               end else if (special) begin
                  state_d   = M_ST_DONE;
                  done_load = 1'b1;
               end else begin
                  state_d  = M_ST_DIV;
                  div_load = 1'b1;
               end
            end
         end
         M_ST_MUL: begin
            result_d = mul_res;
            if (m_if.m_flush) begin
               state_d = M_ST_IDLE;
            end else if (mul_cnt_q == MCW'(MUL_LATENCY - 1)) begin
               state_d   = M_ST_DONE;
               done_load = 1'b1;
            end
         end
         M_ST_DIV: begin
            result_d = div_res;
            if (m_if.m_flush) begin
               state_d = M_ST_IDLE;
            end else begin
               div_step = 1'b1;
               if (div_done) begin
                  state_d   = M_ST_DONE;
                  done_load = 1'b1;
               end
            end
         end
         default: state_d = M_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         func3_q   <= '0;
         rd_q      <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         mul_cnt_q <= '0;
         result_q  <= '0;
         wr_q      <= 1'b0;
         dest_q    <= '0;
      end else begin
         if (accept) begin
            func3_q   <= m_if.m_func3;
            rd_q      <= m_if.m_rd;
            neg_quo_q <= div_signed && (m_if.m_op1[XLEN-1] ^ m_if.m_op2[XLEN-1]);
            neg_rem_q <= div_signed && m_if.m_op1[XLEN-1];
         end
         mul_cnt_q <= (state_q == M_ST_MUL) ? mul_cnt_q + MCW'(1) : '0;
         if (done_load) begin
            result_q <= result_d;
            wr_q     <= (dest_d != 5'd0);
            dest_q   <= dest_d;
         end
      end
   end

   // Stage 0 captures the product in the accept cycle; it reaches the last
   // stage exactly when the MUL state exits.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MUL_LATENCY; i++) mul_pipe[i] <= '0;
      end else begin
         mul_pipe[0] <= prod;
         for (int i = 1; i < MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end

   assign m_if.m_unit_busy   = (state_q != M_ST_IDLE);
   assign m_if.m_unit_ready  = (state_q == M_ST_DONE);
   assign m_if.m_unit_result = result_q;
   assign m_if.m_unit_wr     = wr_q;
   assign m_if.m_unit_dest   = dest_q;
   assign m_if.m_state       = state_q;

endmodule
